// File: rtl/sopc_run_ctrl_pkg.sv
// Shared types and constants for the SoPC run controller.
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    RST_HOLD = 2'd0,
    RUN      = 2'd1,
    HALT     = 2'd2,
    DONE     = 2'd3
  } run_state_e;

  localparam logic RstEnable  = 1'b1;
  localparam logic RstDisable = 1'b0;

  localparam int DEF_N_HALT         = 2;
  localparam int DEF_RST_CYCLES     = 10;
  localparam int DEF_TIMEOUT_CYCLES = 500;
  localparam int DEF_CNT_W          = 32;
  localparam int DEF_LEN_W          = 8;

endpackage

// File: rtl/sopc_run_ctrl_dncnt.sv
// Loadable down-counter that stops at zero and flags it; used for the reset
// hold time and the halt length.
module run_ctrl_dncnt
  import run_ctrl_pkg::*;
#(
  parameter int             W       = 8,
  parameter logic [W-1:0]   RST_VAL = {W{1'b0}}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign zero_o = (cnt_q == {W{1'b0}});

  // load wins over decrement; the count never goes below zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && !zero_o) begin
      cnt_d = cnt_q - W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sopc_run_ctrl.sv
// Run controller for openmips_min_sopc: core reset sequence, halt requests and
// cycle timeout. Optional macro RUN_CTRL_SIM_STOP_EN stops simulation when done rises.
module sopc_run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int N_HALT         = DEF_N_HALT,
  parameter int RST_CYCLES     = DEF_RST_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W          = DEF_CNT_W,
  parameter int LEN_W          = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              soft_restart,
  input  logic              halt_cmd_valid,
  output logic              halt_cmd_ready,
  input  logic [N_HALT-1:0] halt_cmd_mask,
  input  logic [LEN_W-1:0]  halt_cmd_len,
  output logic              cpu_rst,
  output logic [N_HALT-1:0] halt_req,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic              done
);

  localparam int                HOLD_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic              TO_EN     = (TIMEOUT_CYCLES != 0);

  run_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;
  logic [N_HALT-1:0] mask_q, mask_d;
  logic [N_HALT-1:0] halt_req_q, halt_req_d;
  logic              cpu_rst_q, ready_q;

  logic hold_zero_s, hold_load_s, hold_dec_s;
  logic halt_zero_s, halt_load_s, halt_dec_s;
  logic timeout_hit_s, cmd_go_s;

  assign timeout_hit_s = TO_EN && (cnt_q == TO_LAST);
  // zero-length or empty-mask commands are accepted but do nothing
  assign cmd_go_s = halt_cmd_valid && (state_q == RUN)
                    && (halt_cmd_len != {LEN_W{1'b0}})
                    && (halt_cmd_mask != {N_HALT{1'b0}});

  assign hold_load_s = (state_d == RST_HOLD) && (soft_restart || (state_q != RST_HOLD));
  assign hold_dec_s  = (state_q == RST_HOLD);
  assign halt_load_s = (state_q == RUN) && (state_d == HALT);
  assign halt_dec_s  = (state_q == HALT);

  run_ctrl_dncnt #(.W(HOLD_W), .RST_VAL(HOLD_LAST)) u_hold_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (hold_load_s),
    .load_val_i (HOLD_LAST),
    .dec_i      (hold_dec_s),
    .zero_o     (hold_zero_s)
  );

  run_ctrl_dncnt #(.W(LEN_W), .RST_VAL({LEN_W{1'b0}})) u_halt_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (halt_load_s),
    .load_val_i (halt_cmd_len - LEN_W'(1)),
    .dec_i      (halt_dec_s),
    .zero_o     (halt_zero_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    mask_d  = mask_q;
    if (soft_restart) begin
      state_d = RST_HOLD;
      cnt_d   = {CNT_W{1'b0}};
      done_d  = 1'b0;
      mask_d  = {N_HALT{1'b0}};
    end else begin
      case (state_q)
        RST_HOLD: begin
          if (hold_zero_s) begin
            state_d = RUN;
          end else begin
            state_d = RST_HOLD;
          end
        end
        RUN: begin
          if (timeout_hit_s) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cmd_go_s) begin
              state_d = HALT;
              mask_d  = halt_cmd_mask;
            end else begin
              state_d = RUN;
            end
          end
        end
        HALT: begin
          if (timeout_hit_s) begin
            state_d = DONE;
            done_d  = 1'b1;
            mask_d  = {N_HALT{1'b0}};
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            if (halt_zero_s) begin
              state_d = RUN;
              mask_d  = {N_HALT{1'b0}};
            end else begin
              state_d = HALT;
            end
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = RST_HOLD;
          cnt_d   = {CNT_W{1'b0}};
          done_d  = 1'b0;
          mask_d  = {N_HALT{1'b0}};
        end
      endcase
    end
  end

  always_comb begin
    halt_req_d = {N_HALT{1'b0}};
    case (state_d)
      HALT:    halt_req_d = mask_d;
      DONE:    halt_req_d = {N_HALT{1'b1}};
      default: halt_req_d = {N_HALT{1'b0}};
    endcase
  end

  // outputs are decoded from the next state so they line up with state_q
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q    <= RST_HOLD;
      cnt_q      <= {CNT_W{1'b0}};
      done_q     <= 1'b0;
      mask_q     <= {N_HALT{1'b0}};
      halt_req_q <= {N_HALT{1'b0}};
      cpu_rst_q  <= 1'b1;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      mask_q     <= mask_d;
      halt_req_q <= halt_req_d;
      cpu_rst_q  <= (state_d == RST_HOLD);
      ready_q    <= (state_d == RUN);
    end
  end

  assign halt_cmd_ready = ready_q;
  assign cpu_rst        = cpu_rst_q;
  assign halt_req       = halt_req_q;
  assign cycle_cnt      = cnt_q;
  assign done           = done_q;

`ifdef RUN_CTRL_SIM_STOP_EN
  always @(posedge clk) begin
    if ((rst == RstDisable) && (state_q != DONE) && (state_d == DONE)) begin
      $display("sopc_run_ctrl: timeout at cycle_cnt=%0d", cnt_q);
      $stop;
    end
  end
`else
  // done is the only stop indication in this build
`endif

endmodule

// File: tb/tb_sopc_run_ctrl.sv
// Randomized bench for sopc_run_ctrl against a remaining-cycles reference model.
module tb_sopc_run_ctrl;

  localparam int NH = 2;
  localparam int RC = 10;
  localparam int TO = 500;
  localparam int CW = 32;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst, soft_restart, halt_cmd_valid;
  logic [NH-1:0] halt_cmd_mask;
  logic [LW-1:0] halt_cmd_len;
  logic          halt_cmd_ready, cpu_rst, done;
  logic [NH-1:0] halt_req;
  logic [CW-1:0] cycle_cnt;

  always #5 clk = ~clk;

  sopc_run_ctrl #(
    .N_HALT(NH), .RST_CYCLES(RC), .TIMEOUT_CYCLES(TO), .CNT_W(CW), .LEN_W(LW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .soft_restart   (soft_restart),
    .halt_cmd_valid (halt_cmd_valid),
    .halt_cmd_ready (halt_cmd_ready),
    .halt_cmd_mask  (halt_cmd_mask),
    .halt_cmd_len   (halt_cmd_len),
    .cpu_rst        (cpu_rst),
    .halt_req       (halt_req),
    .cycle_cnt      (cycle_cnt),
    .done           (done)
  );

  int n_total = 0;
  int n_pass  = 0;

  // model: cycles of reset still to show, halt cycles still to show
  int          m_rst_left, m_halt_left, m_cnt;
  logic        m_done;
  logic [NH-1:0] m_mask;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endfunction

  task automatic model_step();
    if (rst || soft_restart) begin
      m_rst_left = RC; m_halt_left = 0; m_cnt = 0; m_done = 1'b0; m_mask = '0;
    end else if (!m_done) begin
      if (m_rst_left > 0) begin
        m_rst_left--;
      end else if (m_cnt == TO - 1) begin
        m_done = 1'b1; m_halt_left = 0;
      end else begin
        m_cnt++;
        if (m_halt_left > 0) m_halt_left--;
        else if (halt_cmd_valid && halt_cmd_len != 0 && halt_cmd_mask != 0) begin
          m_halt_left = int'(halt_cmd_len); m_mask = halt_cmd_mask;
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [NH-1:0] exp_halt;
    exp_halt = m_done ? {NH{1'b1}} : (m_halt_left > 0 ? m_mask : {NH{1'b0}});
    chk("cpu_rst", 64'(cpu_rst), 64'(m_rst_left > 0));
    chk("ready", 64'(halt_cmd_ready), 64'(m_rst_left == 0 && m_halt_left == 0 && !m_done));
    chk("halt_req", 64'(halt_req), 64'(exp_halt));
    chk("cycle_cnt", 64'(cycle_cnt), 64'(m_cnt));
    chk("done", 64'(done), 64'(m_done));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle();
    rst = 1'b0; soft_restart = 1'b0; halt_cmd_valid = 1'b0;
  endtask

  task automatic restart_and_wait_run();
    soft_restart = 1'b1; tick(); soft_restart = 1'b0;
    for (int i = 0; i < 20 && m_rst_left > 0; i++) tick();
    chk("reach_run", 64'(halt_cmd_ready), 64'd1);
  endtask

  initial begin
    int hcount, rcount, guard;
    rst = 1'b1; soft_restart = 1'b0; halt_cmd_valid = 1'b0;
    halt_cmd_mask = '0; halt_cmd_len = '0;
    m_rst_left = RC; m_halt_left = 0; m_cnt = 0; m_done = 1'b0; m_mask = '0;

    // reset and release
    repeat (3) tick();
    chk("rst_cpu_rst", 64'(cpu_rst), 64'd1);
    chk("rst_cnt", 64'(cycle_cnt), 64'd0);
    chk("rst_ready", 64'(halt_cmd_ready), 64'd0);
    chk("rst_halt", 64'(halt_req), 64'd0);
    rst = 1'b0;
    repeat (9) tick();
    chk("hold_10th", 64'(cpu_rst), 64'd1);
    tick();
    chk("run_first_rst", 64'(cpu_rst), 64'd0);
    chk("run_first_cnt", 64'(cycle_cnt), 64'd0);
    tick();
    chk("run_second_cnt", 64'(cycle_cnt), 64'd1);

    // halt mask=10 len=5
    halt_cmd_valid = 1'b1; halt_cmd_mask = 2'b10; halt_cmd_len = 8'd5;
    tick();
    halt_cmd_valid = 1'b0;
    chk("halt_ready", 64'(halt_cmd_ready), 64'd0);
    chk("halt_cnt_runs", 64'(cycle_cnt), 64'd2);
    hcount = (halt_req == 2'b10) ? 1 : 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (halt_req == 2'b10) hcount++;
    end
    chk("halt_len5", 64'(hcount), 64'd5);

    // null commands
    halt_cmd_valid = 1'b1; halt_cmd_mask = 2'b11; halt_cmd_len = 8'd0;
    tick();
    halt_cmd_mask = 2'b00; halt_cmd_len = 8'd4;
    tick();
    halt_cmd_valid = 1'b0;
    chk("null_ready", 64'(halt_cmd_ready), 64'd1);
    chk("null_halt", 64'(halt_req), 64'd0);

    // random traffic with occasional restarts
    for (int i = 0; i < 600; i++) begin
      rst            = ($urandom_range(0, 299) == 0);
      soft_restart   = ($urandom_range(0, 99) == 0);
      halt_cmd_valid = ($urandom_range(0, 3) == 0);
      halt_cmd_mask  = NH'($urandom);
      halt_cmd_len   = LW'($urandom_range(0, 12));
      tick();
    end
    idle();

    // timeout under random commands
    restart_and_wait_run();
    guard = 0;
    while (!m_done && guard < 700) begin
      halt_cmd_valid = ($urandom_range(0, 5) == 0);
      halt_cmd_mask  = NH'($urandom);
      halt_cmd_len   = LW'($urandom_range(0, 9));
      tick();
      guard++;
    end
    idle();
    chk("to_done", 64'(done), 64'd1);
    chk("to_cnt", 64'(cycle_cnt), 64'd499);
    chk("to_halt", 64'(halt_req), 64'd3);
    halt_cmd_valid = 1'b1; halt_cmd_mask = 2'b01; halt_cmd_len = 8'd3;
    repeat (5) tick();
    halt_cmd_valid = 1'b0;
    chk("done_frozen", 64'(cycle_cnt), 64'd499);
    chk("done_sticky", 64'(done), 64'd1);

    // halt expiring on the timeout cycle
    restart_and_wait_run();
    for (int i = 0; i < 600 && m_cnt != 494; i++) tick();
    halt_cmd_valid = 1'b1; halt_cmd_mask = 2'b01; halt_cmd_len = 8'd5;
    tick();
    halt_cmd_valid = 1'b0;
    for (int i = 0; i < 20 && !m_done; i++) tick();
    chk("expiry_to_done", 64'(done), 64'd1);
    chk("expiry_to_halt", 64'(halt_req), 64'd3);

    // command on the timeout cycle
    restart_and_wait_run();
    for (int i = 0; i < 600 && m_cnt != 499; i++) tick();
    chk("pre_to_ready", 64'(halt_cmd_ready), 64'd1);
    halt_cmd_valid = 1'b1; halt_cmd_mask = 2'b01; halt_cmd_len = 8'd7;
    tick();
    halt_cmd_valid = 1'b0;
    chk("cmd_to_done", 64'(done), 64'd1);
    chk("cmd_to_halt", 64'(halt_req), 64'd3);
    chk("cmd_to_cnt", 64'(cycle_cnt), 64'd499);

    // soft restart mid-halt, then rst together with soft restart
    for (int pass = 0; pass < 2; pass++) begin
      restart_and_wait_run();
      halt_cmd_valid = 1'b1; halt_cmd_mask = 2'b11; halt_cmd_len = 8'd20;
      tick();
      halt_cmd_valid = 1'b0;
      repeat (6) tick();
      chk("mid_halt", 64'(halt_req), 64'd3);
      soft_restart = 1'b1; rst = (pass == 1);
      tick();
      idle();
      chk("sr_halt", 64'(halt_req), 64'd0);
      chk("sr_cpu_rst", 64'(cpu_rst), 64'd1);
      chk("sr_cnt", 64'(cycle_cnt), 64'd0);
      chk("sr_done", 64'(done), 64'd0);
      rcount = cpu_rst ? 1 : 0;
      for (int i = 0; i < 12; i++) begin
        tick();
        if (cpu_rst) rcount++;
      end
      chk("sr_rst_len", 64'(rcount), 64'd10);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sopc_run_ctrl.md
Name: sopc_run_ctrl

Overview:
- Synthesizable run controller that replaces hand-timed simulation stimulus for the SoPC core.
- Generates the core reset sequence, per-channel halt requests and a cycle-count timeout, all clocked by the core clock.
- Sits between the top-level bench or FPGA wrapper and openmips_min_sopc: drives its rst and halt_req.
- Generalises the fixed 2-bit halt and fixed timing to parametrised channel count, reset length, halt length and timeout.

Parameters:
- N_HALT, 2, number of halt request channels (width of halt_req).
- RST_CYCLES, 10, cycles cpu_rst is held asserted after reset or soft restart; must be >=1.
- TIMEOUT_CYCLES, 500, cycles after reset release before forced stop; 0 disables the timeout.
- CNT_W, 32, width of the cycle counter.
- LEN_W, 8, width of the halt length field.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset for this block (RstEnable = 1).
- soft_restart  in  1  single-cycle pulse; restarts the reset sequence.
- halt_cmd_valid  in  1  halt command strobe.
- halt_cmd_ready  out  1  command accepted when valid&&ready.
- halt_cmd_mask  in  N_HALT  channels to halt.
- halt_cmd_len  in  LEN_W  halt duration in cycles.
- cpu_rst  out  1  reset to core, active-high.
- halt_req  out  N_HALT  halt request per channel.
- cycle_cnt  out  CNT_W  cycles since reset release.
- done  out  1  sticky; timeout reached.

Behaviour:
- One clock domain; rst is synchronous and active-high. All outputs are registered.
- Values while rst=1: state=RST_HOLD, cpu_rst=1, halt_req=0, cycle_cnt=0, done=0, halt_cmd_ready=0, hold counter=RST_CYCLES-1.
- RST_HOLD:
  - cpu_rst=1.
  - Hold counter decrements each cycle; when it is 0, next state is RUN.
  - cpu_rst is therefore high for exactly RST_CYCLES cycles after rst deasserts.
- RUN:
  - cpu_rst=0, halt_req=0, halt_cmd_ready=1.
  - cycle_cnt increments every cycle.
  - On accept with len>0 and mask!=0: latch mask, load len-1 into the halt counter, go to HALT. halt_req=mask from the next cycle.
  - On accept with len=0 or mask=0: the command is consumed and has no effect.
- HALT:
  - halt_req=latched mask, halt_cmd_ready=0, cycle_cnt keeps incrementing.
  - Halt counter decrements; at 0, return to RUN. halt_req is high for exactly len cycles.
- Timeout (TIMEOUT_CYCLES!=0):
  - When cycle_cnt==TIMEOUT_CYCLES-1 in RUN or HALT, next state is DONE.
  - Timeout has priority over a halt command accepted in the same cycle and over halt expiry.
- DONE:
  - done=1, halt_req=all ones, cpu_rst=0, halt_cmd_ready=0.
  - cycle_cnt frozen.
  - Leaves only on rst or soft_restart.
- soft_restart:
  - Accepted in any state; rst has priority over it.
  - Next state RST_HOLD; cycle_cnt, done, halt_req and any pending halt are cleared.
  - It has priority over timeout and over commands in the same cycle.
- cycle_cnt wraps modulo 2^CNT_W when the timeout is disabled.
- Any state encoding outside the enum returns to RST_HOLD.

Optional Feature:
- Macro: RUN_CTRL_SIM_STOP_EN.
- Defined: on the cycle done rises, $display the cycle_cnt value, then call $stop. This is a simulation-only construct.
- Undefined: no system tasks; done is the only indication. This is the synthesizable build.

Decomposition:
- Package run_ctrl_pkg holds:
  - the state enum RST_HOLD/RUN/HALT/DONE;
  - RstEnable/RstDisable constants;
  - default parameter constants.
- One natural sub-module: run_ctrl_dncnt.
  - Loadable down-counter with a zero flag.
  - Instantiated twice: reset hold and halt length.

Test Plan:
- rst high 3 cycles then low, RST_CYCLES=10 -> cpu_rst high for exactly 10 cycles after rst falls; cycle_cnt=0 on first RUN cycle, 1 the next.
- In RUN send mask=2'b10, len=5 -> halt_req=2'b10 for exactly 5 cycles starting next cycle; ready=0 during HALT; cycle_cnt continues incrementing.
- Send len=0, mask=2'b11 -> command consumed, no halt_req, state stays RUN.
- TIMEOUT_CYCLES=500 with no commands -> done rises when cycle_cnt=499 completes; halt_req=2'b11; cycle_cnt frozen at 499. With RUN_CTRL_SIM_STOP_EN the sim stops at that cycle.
- Halt command accepted in the same cycle as timeout -> DONE wins; no partial halt sequence is observed.
- soft_restart pulsed mid-HALT (len=20, 7 cycles in) -> halt_req=0, cpu_rst=1 for 10 cycles, cycle_cnt=0, done=0; a rst pulse during soft restart wins identically.
